// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared FSM states, flag indices and format helpers for the FP multiplier
package fp_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t MUL  = 2'd1;
    localparam state_t NORM = 2'd2;
    localparam state_t DONE = 2'd3;

    // Bit positions inside the 4-bit flags word {nv, of, uf, nx}
    localparam int FLAG_NX = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_NV = 3;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Sign 0, exponent all ones, only the fraction MSB set; caller slices to its word width
    function automatic logic [63:0] fp_canon_qnan(input int exp_w, input int man_w);
        return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
    endfunction

endpackage

// File: rtl/fp_mant_mul.sv
// rtl/fp_mant_mul.sv - sequential shift-add significand multiplier, one partial product per cycle
module fp_mant_mul #(
    parameter int N = 24
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   mcand,
    input  logic [N-1:0]   mplier,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N + 1);

    logic [2*N-1:0] acc;
    logic [2*N-1:0] md;
    logic [N-1:0]   mp;
    logic [CW-1:0]  cnt;
    logic           busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            md   <= '0;
            mp   <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                acc  <= '0;
                md   <= {{N{1'b0}}, mcand};
                mp   <= mplier;
                cnt  <= '0;
                busy <= 1'b1;
            end else if (busy) begin
                if (mp[0]) begin
                    acc <= acc + md;
                end
                md  <= md << 1;
                mp  <= mp >> 1;
                cnt <= cnt + 1'b1;
                // Last of the N partial products; done pulses once the sum is settled
                if (cnt == CW'(N - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign product = acc;

endmodule

// File: rtl/fp_mul_seq.sv
// rtl/fp_mul_seq.sv - sequential IEEE-754-style multiplier with classification, rounding and flags
module fp_mul_seq
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     A,
    input  logic [EXP_W+MAN_W:0]     B,
    input  logic                     rnd_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     Y,
    output logic [3:0]               flags
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int N  = MAN_W + 1;
    localparam int EW = EXP_W + 2;

    localparam logic [63:0]          QNAN_L   = fp_canon_qnan(EXP_W, MAN_W);
    localparam logic [W-1:0]         QNAN     = QNAN_L[W-1:0];
    localparam logic signed [EW-1:0] BIAS     = EW'(fp_bias(EXP_W));
    localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EXP_ZERO = '0;

    state_t state;
    logic                  sign_r;
    logic                  rnd_r;
    logic signed [EW-1:0]  exp_r;
    logic [W-1:0]          y_r;
    logic [3:0]            flags_r;

    logic                  a_sign, b_sign, s_ab;
    logic [EXP_W-1:0]      a_exp, b_exp;
    logic [MAN_W-1:0]      a_frac, b_frac;
    logic                  a_nan, b_nan, a_snan, b_snan;
    logic                  a_inf, b_inf, a_zero, b_zero;
    logic                  special, accept, mul_start, mul_done;
    logic signed [EW-1:0]  exp_sum;
    logic [W-1:0]          spec_y;
    logic [3:0]            spec_flags;
    logic [2*N-1:0]        prod;

    assign a_sign = A[W-1];
    assign b_sign = B[W-1];
    assign a_exp  = A[W-2 -: EXP_W];
    assign b_exp  = B[W-2 -: EXP_W];
    assign a_frac = A[MAN_W-1:0];
    assign b_frac = B[MAN_W-1:0];
    assign s_ab   = a_sign ^ b_sign;

    assign a_nan  = (&a_exp) & (|a_frac);
    assign b_nan  = (&b_exp) & (|b_frac);
    assign a_snan = a_nan & ~a_frac[MAN_W-1];
    assign b_snan = b_nan & ~b_frac[MAN_W-1];
    assign a_inf  = (&a_exp) & ~(|a_frac);
    assign b_inf  = (&b_exp) & ~(|b_frac);
    // Subnormals flush to zero, so an all-zero exponent alone marks a zero operand
    assign a_zero = ~(|a_exp);
    assign b_zero = ~(|b_exp);

    assign special   = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
    assign in_ready  = (state == IDLE);
    assign accept    = in_valid & in_ready;
    assign mul_start = accept & ~special;
    assign exp_sum   = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - BIAS;

    always_comb begin
        spec_y     = {s_ab, {(W-1){1'b0}}};
        spec_flags = 4'b0000;
        if (a_nan | b_nan) begin
            spec_y              = QNAN;
            spec_flags[FLAG_NV] = a_snan | b_snan;
        end else if ((a_inf & b_zero) | (b_inf & a_zero)) begin
            spec_y              = QNAN;
            spec_flags[FLAG_NV] = 1'b1;
        end else if (a_inf | b_inf) begin
            spec_y = {s_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
    end

    fp_mant_mul #(
        .N (N)
    ) u_mant_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .mcand   ({1'b1, a_frac}),
        .mplier  ({1'b1, b_frac}),
        .done    (mul_done),
        .product (prod)
    );

    logic [2*N-2:0]        pn;
    logic [MAN_W-1:0]      mant;
    logic                  guard, sticky, inc, carry;
    logic [MAN_W:0]        mant_r;
    logic signed [EW-1:0]  e_fin;
    logic [W-1:0]          norm_y;
    logic [3:0]            norm_flags;

    // Product lies in [1,4): drop the leading one, shifting left once when it sits one bit lower
    assign pn     = prod[2*N-1] ? prod[2*N-2:0] : {prod[2*N-3:0], 1'b0};
    assign mant   = pn[2*MAN_W -: MAN_W];
    assign guard  = pn[MAN_W];
    assign sticky = |pn[MAN_W-1:0];
    assign inc    = ~rnd_r & guard & (sticky | mant[0]);
    assign mant_r = {1'b0, mant} + {{MAN_W{1'b0}}, inc};
    assign carry  = mant_r[MAN_W];
    assign e_fin  = exp_r + $signed({{(EW-1){1'b0}}, prod[2*N-1]})
                          + $signed({{(EW-1){1'b0}}, carry});

    always_comb begin
        norm_y              = {sign_r, e_fin[EXP_W-1:0], mant_r[MAN_W-1:0]};
        norm_flags          = 4'b0000;
        norm_flags[FLAG_NX] = guard | sticky;
        if (e_fin <= EXP_ZERO) begin
            norm_y              = {sign_r, {(W-1){1'b0}}};
            norm_flags[FLAG_UF] = 1'b1;
            norm_flags[FLAG_NX] = 1'b1;
        end else if (e_fin >= EXP_MAX) begin
            norm_flags[FLAG_OF] = 1'b1;
            norm_flags[FLAG_NX] = 1'b1;
            norm_y = rnd_r ? {sign_r, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                           : {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sign_r  <= 1'b0;
            rnd_r   <= 1'b0;
            exp_r   <= '0;
            y_r     <= '0;
            flags_r <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_r <= s_ab;
                        rnd_r  <= rnd_mode;
                        exp_r  <= exp_sum;
                        if (special) begin
                            y_r     <= spec_y;
                            flags_r <= spec_flags;
                            state   <= DONE;
                        end else begin
                            state <= MUL;
                        end
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    y_r     <= norm_y;
                    flags_r <= norm_flags;
                    state   <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_valid = (state == DONE);
    assign Y         = y_r;
    assign flags     = flags_r;

endmodule

// File: tb/tb_fp_mul_seq.sv
// tb/tb_fp_mul_seq.sv - directed self-checking bench for fp_mul_seq
module tb_fp_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        rnd_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Y;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_mul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .rnd_mode  (rnd_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y),
        .flags     (flags)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic r);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
        A        = a;
        B        = b;
        rnd_mode = r;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 100);
        if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic pop();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b, input logic r,
                       input logic [31:0] ey, input logic [3:0] ef, input int elat);
        int lat;
        send(a, b, r);
        wait_out(lat);
        chk({tag, "_y"}, Y, ey);
        chk({tag, "_flags"}, 32'(flags), 32'(ef));
        chk({tag, "_lat"}, 32'(lat), 32'(elat));
        pop();
    endtask

    initial begin
        int lat;
        logic seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        rnd_mode  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_y", Y, 32'h0);
        chk("rst_flags", 32'(flags), 32'd0);

        run("zero_x_negzero", 32'h00000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, 1);
        run("negzero_sq",     32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000, 1);
        run("mul_rne",        32'h428F4000, 32'hC1200000, 1'b0, 32'hC4331000, 4'b0000, 26);
        run("m1_x_m1",        32'hBF800000, 32'hBF800000, 1'b0, 32'h3F800000, 4'b0000, 26);
        run("exact",          32'h4521B800, 32'h42D34000, 1'b0, 32'h48857316, 4'b0000, 26);
        run("round_rne",      32'h3FAAAAAB, 32'h3FAAAAAB, 1'b0, 32'h3FE38E3A, 4'b0001, 26);
        run("round_trunc",    32'h3FAAAAAB, 32'h3FAAAAAB, 1'b1, 32'h3FE38E39, 4'b0001, 26);
        run("two_x_three",    32'h40000000, 32'h40400000, 1'b1, 32'h40C00000, 4'b0000, 26);
        run("inf_x_zero",     32'h7F800000, 32'h00000000, 1'b0, 32'h7FC00000, 4'b1000, 1);
        run("of_rne",         32'h7F000000, 32'h7F000000, 1'b0, 32'h7F800000, 4'b0101, 26);
        run("of_trunc",       32'h7F000000, 32'h7F000000, 1'b1, 32'h7F7FFFFF, 4'b0101, 26);
        run("uf",             32'h00800000, 32'h80800000, 1'b0, 32'h80000000, 4'b0011, 26);
        run("snan",           32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, 1);
        run("qnan",           32'hFFC00001, 32'h40000000, 1'b0, 32'h7FC00000, 4'b0000, 1);
        run("inf_x_neg",      32'h7F800000, 32'hC0000000, 1'b0, 32'hFF800000, 4'b0000, 1);
        run("subnormal",      32'h80000001, 32'h40000000, 1'b0, 32'h80000000, 4'b0000, 1);

        // Backpressure: result held while a second request waits
        send(32'h40000000, 32'h40400000, 1'b0);
        wait_out(lat);
        @(negedge clk);
        A        = 32'hBF800000;
        B        = 32'hBF800000;
        rnd_mode = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_y", Y, 32'h40C00000);
            chk("bp_hold_flags", 32'(flags), 32'd0);
            chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_out_valid", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_second_accepted", 32'(in_ready), 32'd0);
        wait_out(lat);
        chk("bp_second_lat", 32'(lat), 32'd26);
        chk("bp_second_y", Y, 32'h3F800000);
        pop();

        // Reset in the middle of MUL aborts the operation
        send(32'h428F4000, 32'hC1200000, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_y", Y, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            seen = seen | out_valid;
        end
        chk("abort_no_valid", 32'(seen), 32'd0);

        // Reset wins over a simultaneous request
        @(negedge clk);
        rst      = 1'b1;
        A        = 32'h7F800000;
        B        = 32'h00000000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_over_valid_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("rst_over_valid_out", 32'(out_valid), 32'd0);

        run("after_rst", 32'hBF800000, 32'hBF800000, 1'b0, 32'h3F800000, 4'b0000, 26);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
